platform_collision: RTL and testbench
=====================================

// Module: platform_collision
// PURPOSE
//  Consumer of the platform generator's position arrays. Once per frame it scans
//  the 8 platforms one per clock against the doodle's feet. It reports one landing
//  event: a pulse, the platform index and the platform top Y.
//  Sits between the platform generator and the doodle motion block, which starts
//  a jump on land.
// PARAMETERS
//  DOODLE_W   16   doodle sprite width (px)
//  DOODLE_H   16   doodle sprite height (px); feet_Y = Doodle_Y + DOODLE_H
//  Y_TOL      4    vertical landing window below platform top (px)
//  STATE_INIT 0    game-state code in which scanning is disabled
// PORTS
//  Clk             in   1        50 MHz system clock
//  Reset_n         in   1        synchronous, active-low reset
//  frame_clk_edge  in   2        frame clock edge code; 2'b01 = rising edge (new frame)
//  state           in   8        game state; == STATE_INIT disables block
//  platform_size   in   8        platform width (px), shared by all platforms
//  Platform_X_in   in   10 x [0:7]  platform left X
//  Platform_Y_in   in   10 x [0:7]  platform top Y
//  Doodle_X        in   10       doodle left X
//  Doodle_Y        in   10       doodle top Y
//  Doodle_Y_motion in   10       signed two's-complement Y velocity; >0 = falling
//  land            out  1        1-cycle pulse: landing detected this frame
//  land_idx        out  3        index of platform landed on (valid with land, held after)
//  land_Y          out  10       top Y of that platform (valid with land, held after)
//  busy            out  1        high while snapshot/scan in progress
//  overrun         out  1        sticky: frame edge arrived while busy
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge Clk):
//   - FSM goes to IDLE.
//   - land, land_idx, land_Y, busy and overrun all clear to 0.
//   - Reset wins over every other event, including mid-scan; no pulse is emitted.
//  FSM: IDLE -> SCAN -> REPORT -> IDLE.
//   - IDLE: on frame_clk_edge==2'b01 and state!=STATE_INIT:
//       snapshot all 8 X/Y, Doodle_X/Y, Doodle_Y_motion, platform_size into regs;
//       clear best_valid; set i=0; go to SCAN; busy<=1.
//   - SCAN: evaluate platform i from the snapshot, then i<=i+1. After i==7, go to REPORT.
//     Exactly 8 cycles.
//   - REPORT: land<=best_valid for 1 cycle. If best_valid, load land_idx/land_Y from best.
//     busy<=0; go to IDLE.
//  Latency: edge sampled at posedge k; land is high during cycle k+9 only.
//  Hit test, all arithmetic 11-bit unsigned, zero-extended (no wrap). Hit requires all of:
//   - falling: motion[9]==0 and motion!=0
//   - horizontal overlap: DX+DOODLE_W > PX and DX < PX+platform_size (strict both sides)
//   - vertical window: PY <= DY+DOODLE_H <= PY+Y_TOL
//  Multiple hits: keep the smallest PY. Tie on PY: keep the lower index.
//   Update best only on strictly-smaller PY.
//  No hit: land stays 0; land_idx/land_Y keep their previous values.
//  frame_clk_edge==2'b01 while in SCAN or REPORT:
//   - the edge is ignored (no restart);
//   - overrun<=1, held until reset.
//  state==STATE_INIT: IDLE is held and no scan starts. A scan already in flight completes.
//  Inputs are used only via the snapshot; input changes during SCAN have no effect.
// STRUCTURE
//  doodle_pkg: NUM_PLATFORMS=8, coord_t (logic [9:0]), coll_state_t enum
//   {IDLE,SCAN,REPORT}; shared with platform generator and doodle motion block.
//  Sub-module platform_hit_cmp (combinational): snapshot fields for one platform in,
//   hit flag out. Instantiated once and fed by the scan index mux.
// TESTING
//  1 Reset_n=0 for 2 cycles mid-SCAN -> all outputs 0, no land pulse afterwards.
//  2 P0=(140,40), size 60, DX=150, DY=26 (feet 42), motion=+1, edge at k
//     -> land=1 at k+9 only, land_idx=0, land_Y=40, busy high k+1..k+9.
//  3 Same as 2 with motion=-2 (10'h3FE), then motion=0 -> land never asserts.
//  4 P3=(100,100), P6=(100,98), DX=110, feet=100 -> land_idx=6, land_Y=98.
//     Repeat with P6.Y=100 -> land_idx=3.
//  5 P0.X=140, DX=124 (DX+W=140) -> no land. DX=125 -> land.
//     Also DX=200 with size 60 (DX=PX+size) -> no land.
//  6 Second edge at k+3 -> overrun=1 sticky, single pulse at k+9.
//     state=STATE_INIT with edge -> busy stays 0, no land.

Source files
------------

// File: rtl/platform_collision_pkg.sv
// Shared types and sizes for the platform collision scanner and its neighbours.
package platform_collision_pkg;
    localparam int unsigned NUM_PLATFORMS = 8;
    localparam int unsigned COORD_W       = 10;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned SIZE_W        = 8;
    localparam int unsigned CALC_W        = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} coll_state_t;

    // One platform plus the doodle snapshot, as seen by the hit comparator
    typedef struct packed {
        coord_t             px;
        coord_t             py;
        logic [SIZE_W-1:0]  size;
        coord_t             dx;
        coord_t             dy;
        coord_t             motion;
    } hit_query_t;
endpackage

// File: rtl/platform_collision_if.sv
// Platform arrays and doodle state in, landing report out.
interface platform_collision_if;
    import platform_collision_pkg::*;

    logic [1:0]        frame_clk_edge;
    logic [7:0]        state;
    logic [SIZE_W-1:0] platform_size;
    coord_t            Platform_X_in [NUM_PLATFORMS];
    coord_t            Platform_Y_in [NUM_PLATFORMS];
    coord_t            Doodle_X;
    coord_t            Doodle_Y;
    coord_t            Doodle_Y_motion;
    logic              land;
    logic [IDX_W-1:0]  land_idx;
    coord_t            land_Y;
    logic              busy;
    logic              overrun;

    modport master (
        output frame_clk_edge, state, platform_size, Platform_X_in, Platform_Y_in,
               Doodle_X, Doodle_Y, Doodle_Y_motion,
        input  land, land_idx, land_Y, busy, overrun
    );

    modport slave (
        input  frame_clk_edge, state, platform_size, Platform_X_in, Platform_Y_in,
               Doodle_X, Doodle_Y, Doodle_Y_motion,
        output land, land_idx, land_Y, busy, overrun
    );
endinterface

// File: rtl/platform_collision_hit_cmp.sv
// Combinational landing test of the doodle's feet against one platform.
module platform_collision_hit_cmp
    import platform_collision_pkg::*;
#(
    parameter int unsigned DOODLE_W = 16,
    parameter int unsigned DOODLE_H = 16,
    parameter int unsigned Y_TOL    = 4
) (
    input  hit_query_t query,
    output logic       hit_c
);
    logic [CALC_W-1:0] px, py, dx, feet, size;
    logic              falling, overlap, vwin;

    // Widened to 11 bits so edge sums cannot wrap
    always_comb begin
        px      = CALC_W'(query.px);
        py      = CALC_W'(query.py);
        dx      = CALC_W'(query.dx);
        size    = CALC_W'(query.size);
        feet    = CALC_W'(query.dy) + CALC_W'(DOODLE_H);
        falling = !query.motion[COORD_W-1] && (query.motion != '0);
        overlap = ((dx + CALC_W'(DOODLE_W)) > px) && (dx < (px + size));
        vwin    = (py <= feet) && (feet <= (py + CALC_W'(Y_TOL)));
        hit_c   = falling && overlap && vwin;
    end
endmodule

// File: rtl/platform_collision.sv
// Per-frame scan of all platforms against the doodle's feet; reports the highest landing.
module platform_collision
    import platform_collision_pkg::*;
#(
    parameter int unsigned DOODLE_W   = 16,
    parameter int unsigned DOODLE_H   = 16,
    parameter int unsigned Y_TOL      = 4,
    parameter logic [7:0]  STATE_INIT = 8'd0
) (
    input logic           Clk,
    input logic           Reset_n,
    platform_collision_if.slave bus
);
    coll_state_t       fsm;
    coord_t            snap_x [NUM_PLATFORMS];
    coord_t            snap_y [NUM_PLATFORMS];
    coord_t            snap_dx, snap_dy, snap_motion;
    logic [SIZE_W-1:0] snap_size;
    logic [IDX_W-1:0]  scan_idx;
    logic              best_valid;
    logic [IDX_W-1:0]  best_idx;
    coord_t            best_y;

    logic              land, busy, overrun;
    logic [IDX_W-1:0]  land_idx;
    coord_t            land_Y;

    hit_query_t        query;
    logic              hit_c, take_c, next_valid_c;
    logic [IDX_W-1:0]  next_idx_c;
    coord_t            next_y_c;
    logic              frame_edge_c;

    assign frame_edge_c = (bus.frame_clk_edge == 2'b01);

    always_comb begin
        query = '{px: snap_x[scan_idx], py: snap_y[scan_idx], size: snap_size,
                  dx: snap_dx, dy: snap_dy, motion: snap_motion};
    end

    platform_collision_hit_cmp #(
        .DOODLE_W (DOODLE_W),
        .DOODLE_H (DOODLE_H),
        .Y_TOL    (Y_TOL)
    ) u_hit_cmp (
        .query (query),
        .hit_c (hit_c)
    );

    // Strictly-smaller Y replaces the best, so ties keep the lower index
    always_comb begin
        take_c       = hit_c && (!best_valid || (snap_y[scan_idx] < best_y));
        next_valid_c = best_valid || take_c;
        next_idx_c   = take_c ? scan_idx : best_idx;
        next_y_c     = take_c ? snap_y[scan_idx] : best_y;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fsm        <= IDLE;
            land       <= 1'b0;
            land_idx   <= '0;
            land_Y     <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            scan_idx   <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_y     <= '0;
        end else begin
            land <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (frame_edge_c && (bus.state != STATE_INIT)) begin
                        for (int p = 0; p < int'(NUM_PLATFORMS); p++) begin
                            snap_x[p] <= bus.Platform_X_in[p];
                            snap_y[p] <= bus.Platform_Y_in[p];
                        end
                        snap_dx     <= bus.Doodle_X;
                        snap_dy     <= bus.Doodle_Y;
                        snap_motion <= bus.Doodle_Y_motion;
                        snap_size   <= bus.platform_size;
                        best_valid  <= 1'b0;
                        scan_idx    <= '0;
                        busy        <= 1'b1;
                        fsm         <= SCAN;
                    end
                end
                SCAN: begin
                    if (frame_edge_c) overrun <= 1'b1;
                    best_valid <= next_valid_c;
                    best_idx   <= next_idx_c;
                    best_y     <= next_y_c;
                    scan_idx   <= IDX_W'(scan_idx + IDX_W'(1));
                    // Result of the last platform goes straight to the report registers
                    if (scan_idx == IDX_W'(NUM_PLATFORMS - 1)) begin
                        land <= next_valid_c;
                        if (next_valid_c) begin
                            land_idx <= next_idx_c;
                            land_Y   <= next_y_c;
                        end
                        fsm <= REPORT;
                    end
                end
                REPORT: begin
                    if (frame_edge_c) overrun <= 1'b1;
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.land     = land;
    assign bus.land_idx = land_idx;
    assign bus.land_Y   = land_Y;
    assign bus.busy     = busy;
    assign bus.overrun  = overrun;
endmodule

// File: tb/tb_platform_collision.sv
// Table-driven frames with a scoreboard of expected landings, plus reset, overrun and init-state sequences.
module tb_platform_collision;
    typedef struct {
        string       name;
        logic [2:0]  ia;
        logic [9:0]  xa, ya;
        logic [2:0]  ib;
        logic [9:0]  xb, yb;
        logic [7:0]  size;
        logic [9:0]  dx, dy, motion;
        logic        exp_land;
        logic [2:0]  exp_idx;
        logic [9:0]  exp_y;
    } vec_t;

    typedef struct packed {
        logic        land;
        logic [2:0]  idx;
        logic [9:0]  y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_ov = 1'b0;
    exp_t sb[$];
    vec_t tbl[11];

    platform_collision_if bus();

    platform_collision dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input logic [7:0] st);
        for (int p = 0; p < 8; p++) begin
            bus.Platform_X_in[p] = 10'd0;
            bus.Platform_Y_in[p] = 10'd1000;
        end
        bus.Platform_X_in[v.ia] = v.xa;
        bus.Platform_Y_in[v.ia] = v.ya;
        bus.Platform_X_in[v.ib] = v.xb;
        bus.Platform_Y_in[v.ib] = v.yb;
        bus.platform_size   = v.size;
        bus.Doodle_X        = v.dx;
        bus.Doodle_Y        = v.dy;
        bus.Doodle_Y_motion = v.motion;
        bus.state           = st;
        bus.frame_clk_edge  = 2'b01;
    endtask

    // Edge sampled at posedge k; sample c is taken 1 time unit after posedge k+c
    task automatic run_frame(input vec_t v, input int extra_edge);
        logic busy_ok, land_ok;
        exp_t e;
        @(negedge clk);
        apply(v, 8'd1);
        sb.push_back('{v.exp_land, v.exp_idx, v.exp_y});
        if (extra_edge >= 0) exp_ov = 1'b1;
        busy_ok = 1'b1;
        land_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            bus.frame_clk_edge = (c == extra_edge) ? 2'b01 : 2'b00;
            bus.Platform_Y_in[v.ia] = 10'd0;
            bus.Doodle_X = ~v.dx;
            if (bus.busy !== (c <= 8)) busy_ok = 1'b0;
            if (bus.land !== ((c == 8) && v.exp_land)) land_ok = 1'b0;
        end
        if (sb.size() == 0) begin
            check({v.name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({v.name, "_busy"}, int'(busy_ok), 1);
            check({v.name, "_land"}, int'(land_ok), 1);
            check({v.name, "_idx"}, int'(bus.land_idx), int'(e.idx));
            check({v.name, "_y"}, int'(bus.land_Y), int'(e.y));
            check({v.name, "_ovr"}, int'(bus.overrun), int'(exp_ov));
        end
    endtask

    initial begin
        logic seen_busy, seen_land;
        tbl[0]  = '{"p0_hit",     0, 140, 40,  0, 140, 40,  60, 150, 26, 10'd1,   1'b1, 3'd0, 10'd40};
        tbl[1]  = '{"rising",     0, 140, 40,  0, 140, 40,  60, 150, 26, 10'h3FE, 1'b0, 3'd0, 10'd40};
        tbl[2]  = '{"still",      0, 140, 40,  0, 140, 40,  60, 150, 26, 10'd0,   1'b0, 3'd0, 10'd40};
        tbl[3]  = '{"lower_py",   3, 100, 100, 6, 100, 98,  60, 110, 84, 10'd1,   1'b1, 3'd6, 10'd98};
        tbl[4]  = '{"tie_py",     3, 100, 100, 6, 100, 100, 60, 110, 84, 10'd1,   1'b1, 3'd3, 10'd100};
        tbl[5]  = '{"left_edge",  0, 140, 40,  0, 140, 40,  60, 124, 26, 10'd1,   1'b0, 3'd3, 10'd100};
        tbl[6]  = '{"left_in",    0, 140, 40,  0, 140, 40,  60, 125, 26, 10'd1,   1'b1, 3'd0, 10'd40};
        tbl[7]  = '{"right_edge", 0, 140, 40,  0, 140, 40,  60, 200, 26, 10'd1,   1'b0, 3'd0, 10'd40};
        tbl[8]  = '{"v_bottom",   2, 0,   50,  2, 0,   50,  60, 10,  38, 10'd1,   1'b1, 3'd2, 10'd50};
        tbl[9]  = '{"v_below",    2, 0,   50,  2, 0,   50,  60, 10,  39, 10'd1,   1'b0, 3'd2, 10'd50};
        tbl[10] = '{"v_above",    2, 0,   50,  2, 0,   50,  60, 10,  33, 10'd1,   1'b0, 3'd2, 10'd50};

        apply(tbl[0], 8'd1);
        bus.frame_clk_edge = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        check("rst_land", int'(bus.land), 0);
        check("rst_idx", int'(bus.land_idx), 0);
        check("rst_y", int'(bus.land_Y), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ovr", int'(bus.overrun), 0);

        // Reset asserted in the middle of a hitting scan
        @(negedge clk);
        rst_n = 1'b1;
        apply(tbl[0], 8'd1);
        @(posedge clk);
        #1;
        bus.frame_clk_edge = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", int'(bus.busy), 0);
        check("mid_land", int'(bus.land), 0);
        check("mid_idx", int'(bus.land_idx), 0);
        check("mid_y", int'(bus.land_Y), 0);
        check("mid_ovr", int'(bus.overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_land = 1'b0;
        seen_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.land) seen_land = 1'b1;
            if (bus.busy) seen_busy = 1'b1;
        end
        check("mid_no_pulse", int'(seen_land), 0);
        check("mid_no_busy", int'(seen_busy), 0);

        for (int i = 0; i < 11; i++) run_frame(tbl[i], -1);

        // Init game state: edge must not start a scan
        @(negedge clk);
        apply(tbl[0], 8'd0);
        seen_land = 1'b0;
        seen_busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.frame_clk_edge = 2'b00;
            if (bus.land) seen_land = 1'b1;
            if (bus.busy) seen_busy = 1'b1;
        end
        check("init_busy", int'(seen_busy), 0);
        check("init_land", int'(seen_land), 0);
        check("init_idx", int'(bus.land_idx), 2);

        // Second edge lands at posedge k+3
        run_frame(tbl[0], 2);
        run_frame(tbl[4], -1);

        if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
